// File: rtl/barrel_unshifter_pipe.sv
// Pipelined right/left shift unit with valid/ready flow control.
// One stage per shift-magnitude bit. Stage k applies a 2^k shift when its magnitude bit is set.
module barrel_unshifter_pipe #(
  parameter  int DATA_W  = 8,
  localparam int SHIFT_W = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [SHIFT_W-1:0] shift_mag,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  data_out
);

  localparam logic [1:0] MODE_ROR = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;

  logic [SHIFT_W-1:0] w_valid_vec;
  logic [SHIFT_W-1:0] w_ready;

  genvar gi;
  generate
    for (gi = 0; gi < SHIFT_W; gi++) begin : g_stage
      localparam int SHAMT = 1 << gi;

      logic               w_in_valid;
      logic [DATA_W-1:0]  w_in_data;
      logic [SHIFT_W-1:gi] w_in_mag;
      logic [1:0]         w_in_mode;
      logic [DATA_W-1:0]  w_shifted;
      logic               r_valid;
      logic [DATA_W-1:0]  r_data;

      if (gi == 0) begin : g_src
        assign w_in_valid = in_valid;
        assign w_in_data  = data_in;
        assign w_in_mag   = shift_mag;
        assign w_in_mode  = mode;
      end else begin : g_src
        assign w_in_valid = g_stage[gi-1].r_valid;
        assign w_in_data  = g_stage[gi-1].r_data;
        assign w_in_mag   = g_stage[gi-1].g_meta.r_mag;
        assign w_in_mode  = g_stage[gi-1].g_meta.r_mode;
      end

      // A stage can take a new word unless it and every stage downstream is full and the sink stalls.
      assign w_valid_vec[gi] = r_valid;
      assign w_ready[gi]     = out_ready | ~(&w_valid_vec[SHIFT_W-1:gi]);

      always_comb begin
        w_shifted = w_in_data;
        if (w_in_mag[gi]) begin
          case (w_in_mode)
            MODE_ROR: w_shifted = (w_in_data >> SHAMT) | (w_in_data << (DATA_W - SHAMT));
            MODE_LSR: w_shifted = w_in_data >> SHAMT;
            MODE_ASR: w_shifted = $unsigned($signed(w_in_data) >>> SHAMT);
            default:  w_shifted = (w_in_data << SHAMT) | (w_in_data >> (DATA_W - SHAMT));
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else if (w_ready[gi]) begin
          r_valid <= w_in_valid;
          if (w_in_valid) begin
            r_data <= w_shifted;
          end
        end
      end

      // Only the magnitude bits still to be consumed downstream are carried forward.
      if (gi < SHIFT_W - 1) begin : g_meta
        logic [SHIFT_W-1:gi+1] r_mag;
        logic [1:0]            r_mode;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_mag  <= '0;
            r_mode <= '0;
          end else if (w_ready[gi] && w_in_valid) begin
            r_mag  <= w_in_mag[SHIFT_W-1:gi+1];
            r_mode <= w_in_mode;
          end
        end
      end
    end
  endgenerate

  assign in_ready  = w_ready[0];
  assign out_valid = g_stage[SHIFT_W-1].r_valid;
  assign data_out  = g_stage[SHIFT_W-1].r_data;

endmodule

// File: tb/tb_barrel_unshifter_pipe.sv
// Randomized and directed bench for barrel_unshifter_pipe against a bit-level reference model.
module tb_barrel_unshifter_pipe;
  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  data_in = '0;
  logic [SW-1:0] shift_mag = '0;
  logic [1:0]    mode = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  data_out;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  bit mon_en = 1'b0;
  int max_run = 0;

  barrel_unshifter_pipe #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .shift_mag(shift_mag), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit i of the result is picked from the source bit i+mag (right modes) or i-mag (rotate left).
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int mag, input logic [1:0] md);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      int j;
      j = i + mag;
      case (md)
        2'd0:    r[i] = d[j % W];
        2'd1:    r[i] = (j < W) ? d[j % W] : 1'b0;
        2'd2:    r[i] = (j < W) ? d[j % W] : d[W-1];
        default: r[i] = d[(i - mag + W) % W];
      endcase
    end
    return r;
  endfunction

  // Output monitor: scoreboard pop, stall stability, run-length of out_valid.
  initial begin
    logic          prev_stall;
    logic [W-1:0]  prev_data;
    int            run_len;
    prev_stall = 1'b0;
    prev_data  = '0;
    run_len    = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        run_len    = 0;
      end else if (mon_en) begin
        if (prev_stall) begin
          chk_eq("hold_valid", {31'd0, out_valid}, 32'd1);
          chk_eq("hold_data", {24'd0, data_out}, {24'd0, prev_data});
        end
        run_len = out_valid ? run_len + 1 : 0;
        if (run_len > max_run) max_run = run_len;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk_eq("unexpected_out", {31'd0, out_valid}, 32'd0);
          else chk_eq("data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = data_out;
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input int mag, input logic [1:0] md, input logic [W-1:0] exp);
    int t;
    t = 0;
    in_valid  = 1'b1;
    data_in   = d;
    shift_mag = mag[SW-1:0];
    mode      = md;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      t++;
      if (t > 200) begin
        chk_eq("send_timeout", {31'd0, in_ready}, 32'd1);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] sweep_exp [8];
    logic [W-1:0] mode_exp [4];
    int lat, acc, sent, cyc;
    logic [W-1:0] wd;
    int m;
    logic [1:0] md;
    bit offering;

    sweep_exp = '{8'h81, 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03};
    mode_exp  = '{8'h96, 8'h16, 8'hF6, 8'hA5};

    // Reset state
    #2 rst_n = 1'b0;
    #10;
    chk_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk_eq("rst_data_out", {24'd0, data_out}, 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    #1 chk_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    mon_en    = 1'b1;
    out_ready = 1'b1;

    // Latency of a single word
    send(8'hB4, 3, 2'd0, 8'h96);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk_eq("latency", lat, 3);
    idle(5);

    // All four modes, back to back
    for (int k = 0; k < 4; k++) send(8'hB4, 3, k[1:0], mode_exp[k]);
    idle(6);

    // Magnitude sweep at full throughput
    max_run = 0;
    for (int k = 0; k < 8; k++) send(8'h81, k, 2'd0, sweep_exp[k]);
    idle(6);
    chk_eq("sweep_run", max_run, 8);

    // Backpressure fill, then simultaneous push and pop when full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    shift_mag = '0;
    mode      = 2'd0;
    acc = 0;
    wd  = 8'h01;
    for (int k = 0; k < 8; k++) begin
      data_in = wd;
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(wd);
        acc++;
        wd = wd + 8'h01;
      end
      @(posedge clk); #1;
    end
    data_in = wd;
    chk_eq("bp_accepted", acc, 3);
    @(negedge clk);
    chk_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk_eq("full_push_pop_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) exp_q.push_back(wd);
    @(posedge clk); #1;
    out_ready = 1'b0;
    data_in   = 8'h05;
    @(negedge clk);
    chk_eq("full_after_swap", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h05, 0, 2'd0, 8'h05);
    idle(8);
    chk_eq("bp_drained", exp_q.size(), 0);

    // Randomized traffic
    sent = 0;
    cyc = 0;
    offering = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      out_ready = ($urandom_range(0, 9) < 6);
      if (!offering) begin
        if ($urandom_range(0, 9) < 7) begin
          offering  = 1'b1;
          wd        = W'($urandom);
          m         = int'($urandom_range(0, 7));
          md        = 2'($urandom_range(0, 3));
          in_valid  = 1'b1;
          data_in   = wd;
          shift_mag = m[SW-1:0];
          mode      = md;
        end else begin
          in_valid  = 1'b0;
          data_in   = W'($urandom);
          shift_mag = SW'($urandom);
          mode      = 2'($urandom);
        end
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(wd, m, md));
        sent++;
        offering = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk_eq("rand_sent", sent, 1000);
    chk_eq("rand_drain", exp_q.size(), 0);

    // Reset with words in flight
    out_ready = 1'b0;
    send(8'h3C, 1, 2'd1, ref_shift(8'h3C, 1, 2'd1));
    send(8'h5A, 2, 2'd2, ref_shift(8'h5A, 2, 2'd2));
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk_eq("async_rst_data", {24'd0, data_out}, 32'd0);
    exp_q.delete();
    #10 rst_n = 1'b1;
    #1 chk_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk_eq("post_rst_valid", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
